// File: rtl/ps2_hex_entry_pkg.sv
// rtl/ps2_hex_entry_pkg.sv - scan-code constants, frame FSM states and hex-key decode
package ps2_hex_entry_pkg;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_e;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;

    // Returns {is_hex, nibble} for a scan-set-2 make code.
    function automatic logic [4:0] hex_decode(input logic [7:0] code);
        logic [4:0] r;
        case (code)
            8'h45:   r = 5'h10;
            8'h16:   r = 5'h11;
            8'h1E:   r = 5'h12;
            8'h26:   r = 5'h13;
            8'h25:   r = 5'h14;
            8'h2E:   r = 5'h15;
            8'h36:   r = 5'h16;
            8'h3D:   r = 5'h17;
            8'h3E:   r = 5'h18;
            8'h46:   r = 5'h19;
            8'h1C:   r = 5'h1A;
            8'h32:   r = 5'h1B;
            8'h21:   r = 5'h1C;
            8'h23:   r = 5'h1D;
            8'h24:   r = 5'h1E;
            8'h2B:   r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_hex_entry_rx_frame.sv
// rtl/ps2_hex_entry_rx_frame.sv - PS/2 pin synchroniser, falling-edge sampler and frame FSM
module ps2_rx_frame
    import ps2_hex_entry_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] rx_byte,
    output logic       byte_ready,
    output logic       frame_error
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
    logic                   clk_prev_q, sample_q;
    rx_state_e              state_q, state_d;
    logic [2:0]             bit_cnt_q;
    logic [7:0]             shreg_q;
    logic                   par_ok_q;
    logic [CW-1:0]          tmo_cnt_q;

    logic clk_s, dat_s, fall, timeout;

    assign clk_s   = clk_sync_q[SYNC_STAGES-1];
    assign dat_s   = dat_sync_q[SYNC_STAGES-1];
    assign fall    = clk_prev_q & ~clk_s;
    assign timeout = (state_q != RX_IDLE) && (tmo_cnt_q == CW'(TIMEOUT_CYCLES));

    // Idle-high reset values keep a released bus from looking like a falling edge.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
            sample_q   <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_dat};
            clk_prev_q <= clk_s;
            sample_q   <= fall;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= RX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = RX_IDLE;
        end else if (sample_q) begin
            case (state_q)
                RX_IDLE:   if (!dat_s) state_d = RX_DATA;
                RX_DATA:   if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
                RX_PARITY: state_d = RX_STOP;
                RX_STOP:   state_d = RX_IDLE;
                default:   state_d = RX_IDLE;
            endcase
        end
    end

    always_comb begin
        byte_ready  = 1'b0;
        frame_error = 1'b0;
        if (timeout) begin
            frame_error = 1'b1;
        end else if (sample_q && state_q == RX_STOP) begin
            if (dat_s && par_ok_q) byte_ready  = 1'b1;
            else                   frame_error = 1'b1;
        end
    end

    assign rx_byte = shreg_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            bit_cnt_q <= 3'd0;
            shreg_q   <= 8'h00;
            par_ok_q  <= 1'b0;
            tmo_cnt_q <= '0;
        end else begin
            if (state_q == RX_IDLE || fall) begin
                tmo_cnt_q <= '0;
            end else if (tmo_cnt_q != CW'(TIMEOUT_CYCLES)) begin
                tmo_cnt_q <= tmo_cnt_q + CW'(1);
            end
            if (sample_q) begin
                case (state_q)
                    RX_IDLE: bit_cnt_q <= 3'd0;
                    RX_DATA: begin
                        shreg_q   <= {dat_s, shreg_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                    end
                    RX_PARITY: par_ok_q <= (^shreg_q) ^ dat_s;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_hex_entry.sv
// rtl/ps2_hex_entry.sv - PS/2 hex-digit entry: scan-code decoder and two-digit entry register
module ps2_hex_entry
    import ps2_hex_entry_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] entry_value,
    output logic [1:0] digit_count,
    output logic       entry_valid,
    output logic       frame_error
);

    logic [7:0] rx_byte;
    logic       byte_ready;

    ps2_rx_frame #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_rx (
        .clock       (clock),
        .resetn      (resetn),
        .ps2_clk     (ps2_clk),
        .ps2_dat     (ps2_dat),
        .rx_byte     (rx_byte),
        .byte_ready  (byte_ready),
        .frame_error (frame_error)
    );

    logic [7:0] value_q, value_d;
    logic [1:0] count_q, count_d;
    logic       valid_q, valid_d;
    logic       brk_q, brk_d;
    logic       ext_q, ext_d;
    logic [4:0] hex;

    assign hex = hex_decode(rx_byte);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            value_q <= 8'h00;
            count_q <= 2'd0;
            valid_q <= 1'b0;
            brk_q   <= 1'b0;
            ext_q   <= 1'b0;
        end else begin
            value_q <= value_d;
            count_q <= count_d;
            valid_q <= valid_d;
            brk_q   <= brk_d;
            ext_q   <= ext_d;
        end
    end

    // Enter is honoured with or without the E0 prefix; all other E0 codes are dropped.
    always_comb begin
        value_d = value_q;
        count_d = count_q;
        valid_d = 1'b0;
        brk_d   = brk_q;
        ext_d   = ext_q;
        if (byte_ready) begin
            if (rx_byte == SC_BREAK) begin
                brk_d = 1'b1;
            end else if (rx_byte == SC_EXT) begin
                ext_d = 1'b1;
            end else begin
                brk_d = 1'b0;
                ext_d = 1'b0;
                if (!brk_q) begin
                    if (rx_byte == SC_ENTER) begin
                        if (count_q != 2'd0) begin
                            valid_d = 1'b1;
                            count_d = 2'd0;
                        end
                    end else if (!ext_q) begin
                        if (rx_byte == SC_BKSP) begin
                            value_d = 8'h00;
                            count_d = 2'd0;
                        end else if (hex[4]) begin
                            if (count_q == 2'd0) begin
                                value_d = {4'h0, hex[3:0]};
                                count_d = 2'd1;
                            end else begin
                                value_d = {value_q[3:0], hex[3:0]};
                                count_d = 2'd2;
                            end
                        end
                    end
                end
            end
        end
    end

    assign entry_value = value_q;
    assign digit_count = count_q;
    assign entry_valid = valid_q;

endmodule

// File: tb/tb_ps2_hex_entry.sv
// tb/tb_ps2_hex_entry.sv - directed PS/2 frame bench with commit-strobe scoreboard
module tb_ps2_hex_entry;

    localparam int TMO  = 300;
    localparam int SYNC = 2;
    localparam int HALF = 6;

    logic       clock   = 1'b0;
    logic       resetn  = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] entry_value;
    logic [1:0] digit_count;
    logic       entry_valid;
    logic       frame_error;

    ps2_hex_entry #(
        .TIMEOUT_CYCLES (TMO),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .ps2_clk     (ps2_clk),
        .ps2_dat     (ps2_dat),
        .entry_value (entry_value),
        .digit_count (digit_count),
        .entry_valid (entry_valid),
        .frame_error (frame_error)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks        = 0;
    int errors        = 0;
    int fe_seen       = 0;
    int ev_seen       = 0;
    int fe_base       = 0;
    int last_stop_cyc = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_v;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives frame bits first..last of {stop, parity, data[7:0], start}.
    task automatic ps2_bits(input logic [7:0] b, input bit bad_par, input int first, input int last);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = first; i <= last; i++) begin
            ps2_dat = f[i];
            repeat (HALF) @(negedge clock);
            ps2_clk = 1'b0;
            if (i == 10) last_stop_cyc = cyc;
            repeat (HALF) @(negedge clock);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        ps2_bits(b, 1'b0, 0, 10);
        repeat (20) @(negedge clock);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clock);
        check(tag, exp_q.size(), 0);
    endtask

    always @(negedge clock) begin
        if (resetn) begin
            if (frame_error) fe_seen++;
            if (entry_valid) begin
                ev_seen++;
                check("valid_error_exclusive", frame_error, 0);
                check("strobe_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_v = exp_q.pop_front();
                    check("strobe_value", entry_value, mon_v);
                    check("strobe_latency", cyc, last_stop_cyc + SYNC + 2);
                end
            end
        end
    end

    initial begin
        resetn = 1'b0;
        repeat (5) @(negedge clock);
        check("rst_value", entry_value, 0);
        check("rst_count", digit_count, 0);
        check("rst_valid", entry_valid, 0);
        check("rst_ferr", frame_error, 0);
        resetn = 1'b1;
        repeat (5) @(negedge clock);

        // 1: digits 1,2 with releases, then Enter
        send(8'h16);
        check("t1_count_a", digit_count, 1);
        check("t1_value_a", entry_value, 8'h01);
        send(8'hF0); send(8'h16);
        check("t1_release_count", digit_count, 1);
        send(8'h1E);
        check("t1_count_b", digit_count, 2);
        check("t1_value_b", entry_value, 8'h12);
        send(8'hF0); send(8'h1E);
        check("t1_release_value", entry_value, 8'h12);
        exp_q.push_back(8'h12);
        send(8'h5A);
        drain("t1_drain");
        check("t1_ev_count", ev_seen, 1);
        check("t1_count_after", digit_count, 0);
        check("t1_value_held", entry_value, 8'h12);

        // 2: three digits keep the last two
        send(8'h1C); send(8'h32); send(8'h21);
        check("t2_value", entry_value, 8'hBC);
        check("t2_count", digit_count, 2);
        exp_q.push_back(8'hBC);
        send(8'h5A);
        drain("t2_drain");
        check("t2_ev_count", ev_seen, 2);
        check("t2_fe_none", fe_seen, 0);

        // 3: parity error
        ps2_bits(8'h45, 1'b1, 0, 10);
        repeat (20) @(negedge clock);
        check("t3_fe", fe_seen, 1);
        check("t3_value", entry_value, 8'hBC);
        check("t3_count", digit_count, 0);

        // 4: stalled frame times out, then a clean digit 3
        ps2_bits(8'h26, 1'b0, 0, 4);
        repeat (TMO + 50) @(negedge clock);
        check("t4_fe", fe_seen, 2);
        send(8'h26);
        check("t4_value", entry_value, 8'h03);
        check("t4_count", digit_count, 1);
        check("t4_fe_after", fe_seen, 2);

        // 5: Enter with no digits, then E0 Enter after digit 9
        send(8'h66);
        check("t5_bksp_value", entry_value, 8'h00);
        check("t5_bksp_count", digit_count, 0);
        send(8'h5A);
        check("t5_no_strobe", ev_seen, 2);
        send(8'h46);
        check("t5_value", entry_value, 8'h09);
        exp_q.push_back(8'h09);
        send(8'hE0); send(8'h5A);
        drain("t5_drain");
        check("t5_ev_count", ev_seen, 3);
        check("t5_count_after", digit_count, 0);

        // 6: reset in the middle of a frame, then the remaining bits
        send(8'h3E);
        check("t6_value_pre", entry_value, 8'h08);
        check("t6_count_pre", digit_count, 1);
        ps2_bits(8'h45, 1'b0, 0, 4);
        resetn = 1'b0;
        repeat (3) @(negedge clock);
        check("t6_rst_value", entry_value, 0);
        check("t6_rst_count", digit_count, 0);
        check("t6_rst_valid", entry_valid, 0);
        check("t6_rst_ferr", frame_error, 0);
        resetn = 1'b1;
        repeat (2) @(negedge clock);
        fe_base = fe_seen;
        ps2_bits(8'h45, 1'b0, 5, 10);
        repeat (TMO + 50) @(negedge clock);
        check("t6_value", entry_value, 0);
        check("t6_count", digit_count, 0);
        check("t6_ev_count", ev_seen, 3);
        check("t6_trailing_timeout", fe_seen - fe_base, 1);
        check("t6_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
